// File: rtl/amp_config_sender.sv
// amp_config_sender: two-wire write master that streams a {reg addr, data} table to the class-D amp.
// Build option AMP_CFG_RETRY_EN: a NACKed entry is re-sent (up to 3 retries) before the sequence aborts.
module amp_config_sender #(
    parameter int         CLK_DIV  = 8,
    parameter logic [6:0] DEV_ADDR = 7'h2C,
    parameter int         NUM_REGS = 12
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        send_config_in,
    output logic [4:0]  cfg_index_out,
    input  logic [15:0] cfg_word_in,
    output logic        scl_out,
    output logic        sda_oe_out,
    input  logic        sda_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        nack_out
);
    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [4:0]       LAST_IDX = 5'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_START, ST_SHIFT, ST_ACK, ST_STOP
    } state_t;

    state_t           state, state_nx;
    logic             send_d, trigger, tick, phase_end;
    logic             stop_end, seq_end, last_entry, give_up, retry;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       quarter, byte_idx;
    logic [2:0]       bit_cnt;
    logic [15:0]      word_q;
    logic [7:0]       cur_byte;
    logic             ack_sample, nack_flag;

    assign trigger    = send_config_in & ~send_d;
    assign tick       = busy_out && (state != ST_FETCH) && (div_cnt == DIV_LAST);
    // START and STOP are 3-quarter phases; data and ACK bits use all 4 quarters.
    assign phase_end  = tick && (quarter == (((state == ST_START) || (state == ST_STOP)) ? 2'd2 : 2'd3));
    assign stop_end   = (state == ST_STOP) && phase_end;
    assign last_entry = (cfg_index_out == LAST_IDX);
    assign seq_end    = stop_end && (give_up || (!nack_flag && last_entry));

`ifdef AMP_CFG_RETRY_EN
    logic [1:0] retry_cnt;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            retry_cnt <= 2'd0;
        end else if ((state == ST_IDLE) && trigger) begin
            retry_cnt <= 2'd0;
        end else if (stop_end && !seq_end) begin
            retry_cnt <= retry ? retry_cnt + 2'd1 : 2'd0;
        end
    end

    assign give_up = nack_flag && (retry_cnt == 2'd3);
    assign retry   = nack_flag && (retry_cnt != 2'd3);
`else
    assign give_up = nack_flag;
    assign retry   = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (trigger) state_nx = ST_FETCH;
            ST_FETCH: state_nx = ST_START;
            ST_START: if (phase_end) state_nx = ST_SHIFT;
            ST_SHIFT: if (phase_end && (bit_cnt == 3'd0)) state_nx = ST_ACK;
            ST_ACK:   if (phase_end) state_nx = (ack_sample || (byte_idx == 2'd2)) ? ST_STOP : ST_SHIFT;
            ST_STOP:  if (phase_end) state_nx = seq_end ? ST_IDLE : ST_FETCH;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        case (byte_idx)
            2'd0:    cur_byte = {DEV_ADDR, 1'b0};
            2'd1:    cur_byte = word_q[15:8];
            default: cur_byte = word_q[7:0];
        endcase
    end

    always_comb begin
        scl_out    = 1'b1;
        sda_oe_out = 1'b0;
        case (state)
            ST_START: begin
                scl_out    = (quarter != 2'd2);
                sda_oe_out = (quarter != 2'd0);
            end
            ST_SHIFT: begin
                scl_out    = (quarter == 2'd1) || (quarter == 2'd2);
                sda_oe_out = ~cur_byte[bit_cnt];
            end
            ST_ACK: begin
                scl_out    = (quarter == 2'd1) || (quarter == 2'd2);
            end
            ST_STOP: begin
                scl_out    = (quarter != 2'd0);
                sda_oe_out = (quarter != 2'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            send_d        <= 1'b0;
            div_cnt       <= '0;
            quarter       <= 2'd0;
            bit_cnt       <= 3'd7;
            byte_idx      <= 2'd0;
            word_q        <= 16'd0;
            ack_sample    <= 1'b0;
            nack_flag     <= 1'b0;
            cfg_index_out <= 5'd0;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
            nack_out      <= 1'b0;
        end else begin
            send_d <= send_config_in;

            if ((state == ST_IDLE) || (state == ST_FETCH) || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (state_nx != state) begin
                quarter <= 2'd0;
            end else if (tick) begin
                quarter <= quarter + 2'd1;
            end

            // Counting down from 7 wraps back to 7 after bit 0, ready for the next byte.
            if (state == ST_FETCH) begin
                bit_cnt <= 3'd7;
            end else if ((state == ST_SHIFT) && phase_end) begin
                bit_cnt <= bit_cnt - 3'd1;
            end

            if (state == ST_FETCH) begin
                byte_idx  <= 2'd0;
                word_q    <= cfg_word_in;
                nack_flag <= 1'b0;
            end else if ((state == ST_ACK) && phase_end) begin
                byte_idx <= byte_idx + 2'd1;
                if (ack_sample) nack_flag <= 1'b1;
            end

            if ((state == ST_ACK) && tick && (quarter == 2'd2)) begin
                ack_sample <= sda_in;
            end

            if ((state == ST_IDLE) && trigger) begin
                busy_out      <= 1'b1;
                done_out      <= 1'b0;
                nack_out      <= 1'b0;
                cfg_index_out <= 5'd0;
            end else if (stop_end) begin
                if (seq_end) begin
                    busy_out      <= 1'b0;
                    cfg_index_out <= 5'd0;
                    if (give_up) nack_out <= 1'b1;
                    else         done_out <= 1'b1;
                end else if (!retry) begin
                    cfg_index_out <= cfg_index_out + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_amp_config_sender.sv
// Bench for amp_config_sender: bus-level slave model plus a per-cycle expected waveform built from the table.
// Honours AMP_CFG_RETRY_EN the same way the design does.
module tb_amp_config_sender;
    localparam int         CLK_DIV  = 2;
    localparam int         NUM_REGS = 2;
    localparam logic [7:0] ADDR_W   = {7'h2C, 1'b0};
    localparam int         BOUND    = 20000;
`ifdef AMP_CFG_RETRY_EN
    localparam int ATTEMPTS = 4;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        send_config_in = 1'b0;
    logic [4:0]  cfg_index_out;
    logic [15:0] cfg_word_in;
    logic        scl_out, sda_oe_out, sda_in;
    logic        busy_out, done_out, nack_out;

    logic [15:0] tbl [32];
    logic        slave_pull = 1'b0;

    // expected per-cycle {busy, scl, sda_oe, index}
    logic [7:0]  exp_q [$];
    logic [7:0]  exp_rx [$];
    logic [7:0]  rx_q [$];
    int          nack_list [$];
    logic        cmp_en = 1'b0;
    int          tests = 0;
    int          fails = 0;

    logic        in_xfer, ack_ph, ack_now;
    logic [7:0]  sh;
    int          bit_n, rx_total, stop_cnt;

    assign cfg_word_in = tbl[cfg_index_out];
    assign sda_in      = ~sda_oe_out & ~slave_pull;

    amp_config_sender #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h2C), .NUM_REGS(NUM_REGS)) dut (
        .clk_in(clk_in), .reset(reset), .send_config_in(send_config_in),
        .cfg_index_out(cfg_index_out), .cfg_word_in(cfg_word_in),
        .scl_out(scl_out), .sda_oe_out(sda_oe_out), .sda_in(sda_in),
        .busy_out(busy_out), .done_out(done_out), .nack_out(nack_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic nack_hit(input int n);
        foreach (nack_list[i]) if (nack_list[i] == n) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- model: expected bus waveform ----------------
    task automatic push_ticks(input logic scl, input logic oe, input int n, input logic [4:0] idx);
        for (int i = 0; i < n * CLK_DIV; i++) exp_q.push_back({1'b1, scl, oe, idx});
    endtask

    task automatic push_byte(input logic [7:0] b, input logic [4:0] idx);
        for (int i = 7; i >= 0; i--) begin
            push_ticks(1'b0, ~b[i], 1, idx);
            push_ticks(1'b1, ~b[i], 2, idx);
            push_ticks(1'b0, ~b[i], 1, idx);
        end
        push_ticks(1'b0, 1'b0, 1, idx);
        push_ticks(1'b1, 1'b0, 2, idx);
        push_ticks(1'b0, 1'b0, 1, idx);
    endtask

    // nack_byte: which of the three bytes the slave refuses, or -1 for none
    task automatic push_entry(input logic [15:0] w, input logic [4:0] idx, input int nack_byte);
        logic [7:0] bytes [3];
        bytes = '{ADDR_W, w[15:8], w[7:0]};
        exp_q.push_back({3'b110, idx});
        push_ticks(1'b1, 1'b0, 1, idx);
        push_ticks(1'b1, 1'b1, 1, idx);
        push_ticks(1'b0, 1'b1, 1, idx);
        for (int k = 0; k < 3; k++) begin
            push_byte(bytes[k], idx);
            exp_rx.push_back(bytes[k]);
            if (k == nack_byte) break;
        end
        push_ticks(1'b0, 1'b1, 1, idx);
        push_ticks(1'b1, 1'b1, 1, idx);
        push_ticks(1'b1, 1'b0, 1, idx);
    endtask

    task automatic push_end();
        exp_q.push_back({3'b010, 5'd0});
    endtask

    // ---------------- compare and slave processes ----------------
    task automatic compare_loop();
        logic [7:0] e;
        forever begin
            @(negedge clk_in);
            if (cmp_en && (exp_q.size() > 0)) begin
                e = exp_q.pop_front();
                check("bus_cycle", {busy_out, scl_out, sda_oe_out, cfg_index_out}, e);
            end
        end
    endtask

    task automatic monitor_loop();
        logic line, p_scl, p_sda;
        p_scl = 1'b1;
        p_sda = 1'b1;
        forever begin
            @(negedge clk_in);
            line = ~sda_oe_out & ~slave_pull;
            if (p_scl && scl_out && p_sda && !line) begin
                in_xfer = 1'b1; bit_n = 0; ack_ph = 1'b0;
            end else if (p_scl && scl_out && !p_sda && line) begin
                in_xfer = 1'b0; stop_cnt++;
            end else if (in_xfer && !p_scl && scl_out && (bit_n < 8)) begin
                sh = {sh[6:0], line};
                bit_n++;
                if (bit_n == 8) begin
                    rx_q.push_back(sh);
                    ack_now = !nack_hit(rx_total);
                    rx_total++;
                end
            end else if (in_xfer && p_scl && !scl_out) begin
                if ((bit_n == 8) && !ack_ph) begin
                    ack_ph = 1'b1; slave_pull = ack_now;
                end else if (ack_ph) begin
                    ack_ph = 1'b0; slave_pull = 1'b0; bit_n = 0;
                end
            end
            p_scl = scl_out;
            p_sda = line;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_all();
        exp_q.delete(); exp_rx.delete(); rx_q.delete(); nack_list.delete();
        in_xfer = 1'b0; ack_ph = 1'b0; ack_now = 1'b0; sh = 8'd0; slave_pull = 1'b0;
        bit_n = 0; rx_total = 0; stop_cnt = 0;
        tbl[0] = 16'h0155;
        tbl[1] = 16'h02AA;
    endtask

    task automatic start_seq();
        @(posedge clk_in); #1 send_config_in = 1'b1;
        @(posedge clk_in); #1 send_config_in = 1'b0; cmp_en = 1'b1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (busy_out && (cyc < BOUND)) begin
            @(posedge clk_in); #1 cyc++;
        end
        check("busy_fall", busy_out, 1'b0);
    endtask

    task automatic end_checks(input string tag, input int cyc, input int exp_cyc,
                              input logic exp_done, input logic exp_nack, input int exp_stops);
        repeat (2) @(posedge clk_in);
        #1 cmp_en = 1'b0;
        check({tag, "_cycles"}, cyc, exp_cyc);
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_done"}, done_out, exp_done);
        check({tag, "_nack"}, nack_out, exp_nack);
        check({tag, "_index"}, cfg_index_out, 5'd0);
        check({tag, "_stops"}, stop_cnt, exp_stops);
        check({tag, "_rx_count"}, rx_q.size(), exp_rx.size());
        for (int i = 0; (i < rx_q.size()) && (i < exp_rx.size()); i++) begin
            check({tag, "_rx_byte"}, rx_q[i], exp_rx[i]);
        end
    endtask

    // ---------------- main ----------------
    initial begin
        int cyc, exp_cyc, last_busy;
        logic [7:0] lit [6];
        lit = '{8'h58, 8'h01, 8'h55, 8'h58, 8'h02, 8'hAA};
        foreach (tbl[i]) tbl[i] = 16'h0000;
        clear_all();
        fork
            compare_loop();
            monitor_loop();
        join_none

        // reset state
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_scl", scl_out, 1'b1);
        check("rst_sda_oe", sda_oe_out, 1'b0);
        check("rst_busy", busy_out, 1'b0);
        check("rst_done", done_out, 1'b0);
        check("rst_nack", nack_out, 1'b0);
        check("rst_index", cfg_index_out, 5'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 check("idle_busy", busy_out, 1'b0);

        // normal two-entry sequence
        clear_all();
        push_entry(tbl[0], 5'd0, -1);
        push_entry(tbl[1], 5'd1, -1);
        push_end();
        exp_cyc = exp_q.size();
        start_seq();
        wait_done(cyc);
        end_checks("normal", cyc, exp_cyc, 1'b1, 1'b0, 2);
        check("normal_cycles_lit", cyc, 459);
        for (int i = 0; (i < 6) && (i < rx_q.size()); i++) check("normal_rx_lit", rx_q[i], lit[i]);

        // slave NACKs the address byte of entry 0
        clear_all();
        for (int a = 0; a < ATTEMPTS; a++) begin
            nack_list.push_back(a);
            push_entry(tbl[0], 5'd0, 0);
        end
        push_end();
        exp_cyc = exp_q.size();
        start_seq();
        wait_done(cyc);
        end_checks("nack_addr", cyc, exp_cyc, 1'b0, 1'b1, ATTEMPTS);
        check("nack_addr_cycles_lit", cyc, ATTEMPTS * 85 + 1);

        // request held high with a second rising edge while busy
        clear_all();
        push_entry(tbl[0], 5'd0, -1);
        push_entry(tbl[1], 5'd1, -1);
        push_end();
        @(posedge clk_in); #1 send_config_in = 1'b1;
        @(posedge clk_in); #1 cmp_en = 1'b1;
        last_busy = busy_out ? 1 : 0;
        for (int c = 2; c <= 500; c++) begin
            @(posedge clk_in); #1;
            if (c == 98) send_config_in = 1'b0;
            if (c == 100) send_config_in = 1'b1;
            if (busy_out) last_busy = c;
        end
        send_config_in = 1'b0;
        repeat (5) @(posedge clk_in);
        #1 check("hold_busy_after", busy_out, 1'b0);
        end_checks("hold", last_busy + 1, 459, 1'b1, 1'b0, 2);

        // reset mid-SHIFT, then clean restart
        clear_all();
        push_entry(tbl[0], 5'd0, -1);
        push_entry(tbl[1], 5'd1, -1);
        push_end();
        start_seq();
        repeat (59) @(posedge clk_in);
        #1 cmp_en = 1'b0;
        reset = 1'b1;
        @(posedge clk_in); #1;
        check("midrst_scl", scl_out, 1'b1);
        check("midrst_sda_oe", sda_oe_out, 1'b0);
        check("midrst_busy", busy_out, 1'b0);
        check("midrst_index", cfg_index_out, 5'd0);
        check("midrst_done", done_out, 1'b0);
        reset = 1'b0;
        repeat (4) @(posedge clk_in);
        #1 clear_all();
        push_entry(tbl[0], 5'd0, -1);
        push_entry(tbl[1], 5'd1, -1);
        push_end();
        exp_cyc = exp_q.size();
        start_seq();
        wait_done(cyc);
        end_checks("restart", cyc, exp_cyc, 1'b1, 1'b0, 2);

        // table words change right after each FETCH latch
        clear_all();
        push_entry(tbl[0], 5'd0, -1);
        push_entry(tbl[1], 5'd1, -1);
        push_end();
        exp_cyc = exp_q.size();
        start_seq();
        cyc = 1;
        while (busy_out && (cyc < BOUND)) begin
            @(posedge clk_in); #1 cyc++;
            if (cyc == 2) tbl[0] = 16'hFFFF;
            if (cyc == 231) tbl[1] = 16'h0000;
        end
        check("latch_busy_fall", busy_out, 1'b0);
        end_checks("latch", cyc, exp_cyc, 1'b1, 1'b0, 2);

`ifdef AMP_CFG_RETRY_EN
        // data byte of entry 1 refused twice, then accepted
        clear_all();
        nack_list = '{5, 8};
        push_entry(tbl[0], 5'd0, -1);
        push_entry(tbl[1], 5'd1, 2);
        push_entry(tbl[1], 5'd1, 2);
        push_entry(tbl[1], 5'd1, -1);
        push_end();
        exp_cyc = exp_q.size();
        start_seq();
        wait_done(cyc);
        end_checks("retry_ok", cyc, exp_cyc, 1'b1, 1'b0, 4);

        // four refusals exhaust the retries
        clear_all();
        nack_list = '{5, 8, 11, 14};
        push_entry(tbl[0], 5'd0, -1);
        for (int a = 0; a < 4; a++) push_entry(tbl[1], 5'd1, 2);
        push_end();
        exp_cyc = exp_q.size();
        start_seq();
        wait_done(cyc);
        end_checks("retry_fail", cyc, exp_cyc, 1'b0, 1'b1, 5);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
